// File: rtl/dec_scan_n.sv
// Registered N-to-2^N one-hot decoder with a self-timed scan mode and wrap strobe.
// Optional anti-ghosting blank gap between scan steps: define DEC_SCAN_GAP_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | decoder disabled, out blank, idx held
// DIRECT | out follows 1<<in every cycle
// SCAN   | out walks 1<<idx, idx advances every DIV cycles
// GAP    | one blank cycle after each step (DEC_SCAN_GAP_EN only)

module dec_scan_n #(
    parameter int IN_W = 3,
    parameter int DIV  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   mode,
    input  logic [IN_W-1:0]        in,
    input  logic                   load,
    output logic [(1<<IN_W)-1:0]   out,
    output logic [IN_W-1:0]        idx,
    output logic                   wrap
);

    localparam int OUT_W = 1 << IN_W;
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

`ifdef DEC_SCAN_GAP_EN
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
`endif

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   out_nxt;
    logic [IN_W-1:0]    idx_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               wrap_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out   <= '0;
            idx   <= '0;
            cnt   <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            out   <= out_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            wrap  <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_nxt   = out;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        wrap_nxt  = 1'b0;

        if (!en) begin
            state_nxt = IDLE;
            out_nxt   = '0;
            cnt_nxt   = '0;
        end else if (!mode) begin
            state_nxt = DIRECT;
            idx_nxt   = in;
            out_nxt   = OUT_W'(1) << in;
            cnt_nxt   = '0;
        end else begin
            case (state)
                SCAN: begin
                    if (load) begin
                        idx_nxt = in;
                        out_nxt = OUT_W'(1) << in;
                        cnt_nxt = '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + CW'(1);
                    end else begin
                        // step: old idx at the top of the range means this is the wrap edge
                        cnt_nxt  = '0;
                        idx_nxt  = idx + IN_W'(1);
                        wrap_nxt = (idx == '1);
`ifdef DEC_SCAN_GAP_EN
                        out_nxt   = '0;
                        state_nxt = GAP;
`else
                        out_nxt   = OUT_W'(1) << (idx + IN_W'(1));
`endif
                    end
                end
`ifdef DEC_SCAN_GAP_EN
                GAP: begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                    if (load) begin
                        idx_nxt = in;
                        out_nxt = OUT_W'(1) << in;
                    end else begin
                        out_nxt = OUT_W'(1) << idx;
                    end
                end
`endif
                default: begin
                    // entry from IDLE/DIRECT; prescaler always restarts
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                    if (load) begin
                        idx_nxt = in;
                        out_nxt = OUT_W'(1) << in;
                    end else begin
                        out_nxt = OUT_W'(1) << idx;
                    end
                end
            endcase
        end
    end

endmodule
